// File: rtl/mul_unit.sv
// Iterative multiply / multiply-accumulate unit (MUL, MLA, UMULL, UMLAL, SMULL, SMLAL).
// Retires BPC multiplier bits per cycle and stops early once the remaining multiplier is zero.
//
//  state | meaning
//  IDLE  | waiting for start; outputs hold the last result
//  MUL   | accumulating partial products, BPC multiplier bits per cycle
//  FIX   | sign fix-up, accumulate, register outputs, pulse done
module mul_unit #(
  parameter int WIDTH = 32,
  parameter int BPC   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic             n,
  input  logic             z,
  input  logic             c,
  input  logic             v,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_n,
  output logic             out_z,
  output logic             out_c,
  output logic             out_v
);

  localparam int SW = $clog2(WIDTH) + 1;
  localparam logic [SW-1:0] LAST_SHIFT = SW'(WIDTH - BPC);
  localparam logic [SW-1:0] STEP       = SW'(BPC);

  typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   product;
  logic [SW-1:0]        shift;
  logic                 neg;
  logic                 is_long;
  logic                 is_acc;
  logic                 c_lat;
  logic                 v_lat;
  logic [WIDTH-1:0]     acc_lo_q;
  logic [WIDTH-1:0]     acc_hi_q;

  // Incoming n and z are always replaced by result-derived values.
  logic unused_flags;
  assign unused_flags = n ^ z;

  logic                 is_signed_in;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [2*WIDTH-1:0]   partial;
  logic [2*WIDTH-1:0]   product_next;
  logic [WIDTH-1:0]     mplier_next;
  logic [2*WIDTH-1:0]   prod_fixed;
  logic [2*WIDTH-1:0]   acc_ext;
  logic [2*WIDTH-1:0]   result;

  // The most negative operand maps onto itself, read back as unsigned 2^(W-1).
  always_comb begin
    is_signed_in = opcode[2] & opcode[1];
    abs_a        = (is_signed_in && a[WIDTH-1]) ? -a : a;
    abs_b        = (is_signed_in && b[WIDTH-1]) ? -b : b;
  end

  always_comb begin
    partial      = ({{WIDTH{1'b0}}, mcand} * {{(2*WIDTH-BPC){1'b0}}, mplier[BPC-1:0]}) << shift;
    product_next = product + partial;
    mplier_next  = mplier >> BPC;
  end

  always_comb begin
    prod_fixed = neg ? -product : product;
    acc_ext    = is_long ? {acc_hi_q, acc_lo_q} : {{WIDTH{1'b0}}, acc_lo_q};
    result     = is_acc ? prod_fixed + acc_ext : prod_fixed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_lo   <= '0;
      out_hi   <= '0;
      out_n    <= 1'b0;
      out_z    <= 1'b0;
      out_c    <= 1'b0;
      out_v    <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      product  <= '0;
      shift    <= '0;
      neg      <= 1'b0;
      is_long  <= 1'b0;
      is_acc   <= 1'b0;
      c_lat    <= 1'b0;
      v_lat    <= 1'b0;
      acc_lo_q <= '0;
      acc_hi_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand    <= abs_a;
            mplier   <= abs_b;
            neg      <= is_signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
            is_long  <= opcode[2];
            is_acc   <= opcode[0];
            c_lat    <= c;
            v_lat    <= v;
            acc_lo_q <= acc_lo;
            acc_hi_q <= acc_hi;
            product  <= '0;
            shift    <= '0;
            busy     <= 1'b1;
            state    <= MUL;
          end
        end
        MUL: begin
          product <= product_next;
          mplier  <= mplier_next;
          shift   <= shift + STEP;
          if (mplier_next == '0 || shift == LAST_SHIFT) state <= FIX;
        end
        FIX: begin
          out_lo <= result[WIDTH-1:0];
          out_c  <= c_lat;
          out_v  <= v_lat;
          if (is_long) begin
            out_hi <= result[2*WIDTH-1:WIDTH];
            out_n  <= result[2*WIDTH-1];
            out_z  <= (result == '0);
          end else begin
            out_hi <= '0;
            out_n  <= result[WIDTH-1];
            out_z  <= (result[WIDTH-1:0] == '0);
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
